// File: rtl/coin_tracker.sv
// ============================================================================
// coin_tracker
// ----------------------------------------------------------------------------
// Coin-collection tracker for Flappy-VGA. Every cycle the bird's bounding box
// is tested against N_COINS coin boxes coming from the coin generator. On a
// collection the module does three things:
//   - it latches a per-coin "taken" flag,
//   - it raises a one-cycle collection strobe,
//   - it adds the number of coins collected that cycle to a saturating score.
// It also keeps a high score and follows the Start/Ack game flow
// (idle -> play -> done -> idle).
//
// Parameters
//   N_COINS     number of coin channels
//   COORD_W     width of every screen coordinate
//   COIN_HEIGHT coin height in pixels
//   SCORE_W     width of the score and high-score counters
//
// Ports
//   Clk         in   single clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   Start       in   begin a game (honoured only in QI)
//   Ack         in   acknowledge game over (honoured only in QDONE)
//   Game_Over   in   level from the pole-collision logic
//   Bird_X_L/R  in   bird left/right edge          [COORD_W]
//   Bird_Y_T/B  in   bird top/bottom edge          [COORD_W]
//   Coin_X_L/R  in   packed coin left/right edges  [N_COINS*COORD_W]
//   Coin_Y      in   packed coin top edges         [N_COINS*COORD_W]
//   Coin_Valid  in   coin i is on screen           [N_COINS]
//   Coin_Taken  out  coin i has been collected     [N_COINS]
//   Coin_Pulse  out  one-cycle strobe on any collection
//   Score       out  coins collected this game     [SCORE_W]
//   High_Score  out  best score since reset        [SCORE_W]
//   State       out  QI=0, QPLAY=1, QDONE=2
// ============================================================================
module coin_tracker #(
    parameter int N_COINS     = 4,
    parameter int COORD_W     = 10,
    parameter int COIN_HEIGHT = 20,
    parameter int SCORE_W     = 8
) (
    input  logic                         Clk,
    input  logic                         reset_n,
    input  logic                         Start,
    input  logic                         Ack,
    input  logic                         Game_Over,
    input  logic [COORD_W-1:0]           Bird_X_L,
    input  logic [COORD_W-1:0]           Bird_X_R,
    input  logic [COORD_W-1:0]           Bird_Y_T,
    input  logic [COORD_W-1:0]           Bird_Y_B,
    input  logic [N_COINS*COORD_W-1:0]   Coin_X_L,
    input  logic [N_COINS*COORD_W-1:0]   Coin_X_R,
    input  logic [N_COINS*COORD_W-1:0]   Coin_Y,
    input  logic [N_COINS-1:0]           Coin_Valid,
    output logic [N_COINS-1:0]           Coin_Taken,
    output logic                         Coin_Pulse,
    output logic [SCORE_W-1:0]           Score,
    output logic [SCORE_W-1:0]           High_Score,
    output logic [1:0]                   State
);

    // Coordinates are compared one bit wider so Coin_Y + COIN_HEIGHT never wraps.
    localparam int EXT_W = COORD_W + 1;
    // Enough bits to hold a popcount of 0..N_COINS.
    localparam int CNT_W = $clog2(N_COINS + 1);
    // Score plus popcount fits here without overflow, so saturation is exact.
    localparam int SUM_W = SCORE_W + CNT_W;

    localparam logic [EXT_W-1:0]   L_COIN_H    = EXT_W'(COIN_HEIGHT);
    localparam logic [SCORE_W-1:0] L_SCORE_MAX = {SCORE_W{1'b1}};

    typedef enum logic [1:0] {
        QI    = 2'd0,
        QPLAY = 2'd1,
        QDONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t               r_state;
    logic [N_COINS-1:0]   r_taken;
    logic                 r_pulse;
    logic [SCORE_W-1:0]   r_score;
    logic [SCORE_W-1:0]   r_high_score;

    state_t               w_state_nxt;
    logic [N_COINS-1:0]   w_taken_nxt;
    logic                 w_pulse_nxt;
    logic [SCORE_W-1:0]   w_score_nxt;
    logic [SCORE_W-1:0]   w_high_score_nxt;

    // ------------------------------------------------------------------------
    // Bounding-box overlap, one comparator set per coin
    // ------------------------------------------------------------------------
    logic [EXT_W-1:0]     w_bird_xl;
    logic [EXT_W-1:0]     w_bird_xr;
    logic [EXT_W-1:0]     w_bird_yt;
    logic [EXT_W-1:0]     w_bird_yb;
    logic [N_COINS-1:0]   w_overlap;

    assign w_bird_xl = {1'b0, Bird_X_L};
    assign w_bird_xr = {1'b0, Bird_X_R};
    assign w_bird_yt = {1'b0, Bird_Y_T};
    assign w_bird_yb = {1'b0, Bird_Y_B};

    for (genvar g = 0; g < N_COINS; g++) begin : g_coin
        logic [EXT_W-1:0] w_coin_xl;
        logic [EXT_W-1:0] w_coin_xr;
        logic [EXT_W-1:0] w_coin_yt;
        logic [EXT_W-1:0] w_coin_yb;

        assign w_coin_xl = {1'b0, Coin_X_L[g*COORD_W +: COORD_W]};
        assign w_coin_xr = {1'b0, Coin_X_R[g*COORD_W +: COORD_W]};
        assign w_coin_yt = {1'b0, Coin_Y[g*COORD_W +: COORD_W]};
        assign w_coin_yb = w_coin_yt + L_COIN_H;

        // Strict inequalities: boxes that only share an edge do not overlap.
        assign w_overlap[g] = (w_bird_xr > w_coin_xl) &&
                              (w_bird_xl < w_coin_xr) &&
                              (w_bird_yb > w_coin_yt) &&
                              (w_bird_yt < w_coin_yb);
    end

    // ------------------------------------------------------------------------
    // Hit qualification
    // ------------------------------------------------------------------------
    // A coin that is already taken cannot hit again. This is what makes a
    // continuously overlapping coin count once until the generator re-arms it.
    // Game_Over suppresses hits in the same cycle, so the score committed to
    // the high score never includes a coin touched on the losing frame.
    logic                 w_collect_en;
    logic [N_COINS-1:0]   w_hit;

    assign w_collect_en = (r_state == QPLAY) && !Game_Over;
    assign w_hit        = w_overlap & Coin_Valid & ~r_taken & {N_COINS{w_collect_en}};

    // ------------------------------------------------------------------------
    // Popcount of hits and saturating score add
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0]     w_hit_cnt;
    logic [SUM_W-1:0]     w_score_sum;
    logic [SCORE_W-1:0]   w_score_sat;

    // NOTE: every signal written in an always_comb gets a default on entry;
    // if any path leaves one unassigned, synthesis infers a latch for it.
    always_comb begin
        w_hit_cnt = '0;
        for (int i = 0; i < N_COINS; i++) begin
            w_hit_cnt = w_hit_cnt + CNT_W'(w_hit[i]);
        end
    end

    assign w_score_sum = SUM_W'(r_score) + SUM_W'(w_hit_cnt);
    assign w_score_sat = (w_score_sum > SUM_W'(L_SCORE_MAX)) ? L_SCORE_MAX
                                                             : w_score_sum[SCORE_W-1:0];

    // ------------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_taken_nxt      = r_taken;
        w_pulse_nxt      = 1'b0;
        w_score_nxt      = r_score;
        w_high_score_nxt = r_high_score;

        case (r_state)
            QI: begin
                w_taken_nxt = '0;
                w_score_nxt = '0;
                if (Start) begin
                    w_state_nxt = QPLAY;
                end
            end

            QPLAY: begin
                // Dropping Coin_Valid re-arms a coin. It wins over a hit in
                // the same cycle, because w_hit already requires Coin_Valid.
                w_taken_nxt = (r_taken | w_hit) & Coin_Valid;
                w_pulse_nxt = |w_hit;
                w_score_nxt = w_score_sat;
                if (Game_Over) begin
                    w_state_nxt = QDONE;
                    // The score cannot change on this edge because hits are
                    // suppressed, so r_score is the final game score.
                    if (r_score > r_high_score) begin
                        w_high_score_nxt = r_score;
                    end
                end
            end

            QDONE: begin
                // Everything is frozen until the player acknowledges.
                if (Ack) begin
                    w_state_nxt = QI;
                    w_taken_nxt = '0;
                    w_score_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = QI;
                w_taken_nxt = '0;
                w_score_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples its pre-edge next value no matter how the statements are ordered.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= QI;
            r_taken      <= '0;
            r_pulse      <= 1'b0;
            r_score      <= '0;
            r_high_score <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_taken      <= w_taken_nxt;
            r_pulse      <= w_pulse_nxt;
            r_score      <= w_score_nxt;
            r_high_score <= w_high_score_nxt;
        end
    end

    assign Coin_Taken = r_taken;
    assign Coin_Pulse = r_pulse;
    assign Score      = r_score;
    assign High_Score = r_high_score;
    assign State      = r_state;

endmodule

// File: tb/tb_coin_tracker.sv
// ============================================================================
// tb_coin_tracker
// ----------------------------------------------------------------------------
// Directed bench for coin_tracker. There are two instances on the same
// stimulus: the default configuration (SCORE_W=8) and a narrow-score build
// (SCORE_W=3) that is used for the saturation case. Inputs change 1 time unit
// after the rising edge, and outputs are sampled at the same point, so every
// comparison sees the result of the edge that was just taken.
// ============================================================================
module tb_coin_tracker;

    logic        Clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic        start   = 1'b0;
    logic        ack     = 1'b0;
    logic        game_over = 1'b0;
    logic [9:0]  bxl, bxr, byt, byb;
    logic [9:0]  cxl [4];
    logic [9:0]  cxr [4];
    logic [9:0]  cy  [4];
    logic [39:0] coin_xl, coin_xr, coin_y;
    logic [3:0]  valid;

    logic [3:0]  taken;
    logic        pulse;
    logic [7:0]  score;
    logic [7:0]  high_score;
    logic [1:0]  state;

    logic [3:0]  taken3;
    logic        pulse3;
    logic [2:0]  score3;
    logic [2:0]  high_score3;
    logic [1:0]  state3;

    int checks   = 0;
    int failures = 0;
    int pulses;

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign coin_xl[g*10 +: 10] = cxl[g];
        assign coin_xr[g*10 +: 10] = cxr[g];
        assign coin_y[g*10 +: 10]  = cy[g];
    end

    coin_tracker #(.N_COINS(4), .COORD_W(10), .COIN_HEIGHT(20), .SCORE_W(8)) dut (
        .Clk(Clk), .reset_n(reset_n), .Start(start), .Ack(ack), .Game_Over(game_over),
        .Bird_X_L(bxl), .Bird_X_R(bxr), .Bird_Y_T(byt), .Bird_Y_B(byb),
        .Coin_X_L(coin_xl), .Coin_X_R(coin_xr), .Coin_Y(coin_y), .Coin_Valid(valid),
        .Coin_Taken(taken), .Coin_Pulse(pulse), .Score(score),
        .High_Score(high_score), .State(state)
    );

    coin_tracker #(.N_COINS(4), .COORD_W(10), .COIN_HEIGHT(20), .SCORE_W(3)) dut3 (
        .Clk(Clk), .reset_n(reset_n), .Start(start), .Ack(ack), .Game_Over(game_over),
        .Bird_X_L(bxl), .Bird_X_R(bxr), .Bird_Y_T(byt), .Bird_Y_B(byb),
        .Coin_X_L(coin_xl), .Coin_X_R(coin_xr), .Coin_Y(coin_y), .Coin_Valid(valid),
        .Coin_Taken(taken3), .Coin_Pulse(pulse3), .Score(score3),
        .High_Score(high_score3), .State(state3)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic bird(input int xl, input int xr, input int yt, input int yb);
        bxl = 10'(xl);
        bxr = 10'(xr);
        byt = 10'(yt);
        byb = 10'(yb);
    endtask

    task automatic park();
        bird(0, 10, 0, 10);
    endtask

    task automatic on_coin0();
        bird(110, 125, 205, 215);
    endtask

    initial begin
        // Coin layout: coins 1 and 3 overlap each other so that one bird box
        // can touch both in the same cycle.
        cxl = '{10'd100, 10'd300, 10'd500, 10'd310};
        cxr = '{10'd120, 10'd320, 10'd520, 10'd330};
        cy  = '{10'd200, 10'd200, 10'd200, 10'd200};
        valid = 4'hF;
        park();

        // ---------------- Asynchronous reset, no clock needed ----------------
        #1 reset_n = 1'b0;
        #2;
        check("rst_state", state, 0);
        check("rst_taken", taken, 0);
        check("rst_pulse", pulse, 0);
        check("rst_score", score, 0);
        check("rst_hs",    high_score, 0);
        check("rst_score3", score3, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_state", state, 0);

        // ---------------- Idle: an overlap does not collect ----------------
        on_coin0();
        tick();
        check("qi_pulse", pulse, 0);
        check("qi_score", score, 0);
        check("qi_taken", taken, 0);
        park();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_state", state, 1);

        // ---------------- Single hit ----------------
        on_coin0();
        tick();
        check("hit_pulse", pulse, 1);
        check("hit_score", score, 1);
        check("hit_taken", taken, 4'b0001);

        // ---------------- Held overlap counts once ----------------
        pulses = 0;
        repeat (49) begin
            tick();
            pulses += int'(pulse);
        end
        check("hold_pulses", pulses, 0);
        check("hold_score", score, 1);
        check("hold_taken", taken, 4'b0001);

        // ---------------- Re-arm by dropping valid ----------------
        valid = 4'b1110;
        tick();
        check("rearm_taken", taken, 4'b0000);
        check("rearm_pulse", pulse, 0);
        valid = 4'hF;
        tick();
        check("rearm_hit_pulse", pulse, 1);
        check("rearm_hit_score", score, 2);
        check("rearm_hit_taken", taken, 4'b0001);
        tick();
        check("rearm_pulse_one_cycle", pulse, 0);

        // ---------------- Edge contact is not a hit ----------------
        bird(490, 500, 205, 215);
        tick();
        check("edge_x_pulse", pulse, 0);
        bird(505, 515, 220, 230);
        tick();
        check("edge_y_pulse", pulse, 0);
        check("edge_y_score", score, 2);
        bird(505, 515, 219, 230);
        tick();
        check("inside_y_pulse", pulse, 1);
        check("inside_y_score", score, 3);
        check("inside_y_taken", taken, 4'b0101);

        // ---------------- Simultaneous hits on coins 1 and 3 ----------------
        bird(312, 318, 205, 215);
        tick();
        check("multi_pulse", pulse, 1);
        check("multi_score", score, 5);
        check("multi_taken", taken, 4'b1111);
        tick();
        check("multi_pulse_one_cycle", pulse, 0);

        // ---------------- Game_Over beats a same-cycle overlap ----------------
        valid = 4'b1110;
        tick();
        check("pre_go_taken", taken, 4'b1110);
        on_coin0();
        valid = 4'hF;
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        check("go_state", state, 2);
        check("go_hs", high_score, 5);
        check("go_score", score, 5);
        check("go_pulse", pulse, 0);
        check("go_taken", taken, 4'b1110);

        // ---------------- Done: Start ignored, frozen; Ack returns ----------------
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_start_ignored", state, 2);
        check("done_score", score, 5);
        check("done_taken", taken, 4'b1110);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ack_state", state, 0);
        check("ack_score", score, 0);
        check("ack_taken", taken, 0);
        check("ack_hs", high_score, 5);

        // ---------------- Second game: back-to-back hits, lower score ----------------
        start = 1'b1;
        tick();
        start = 1'b0;
        check("game2_state", state, 1);
        tick();
        check("b2b_pulse1", pulse, 1);
        check("b2b_score1", score, 1);
        bird(505, 515, 205, 215);
        tick();
        check("b2b_pulse2", pulse, 1);
        check("b2b_score2", score, 2);
        check("b2b_taken", taken, 4'b0101);
        park();
        start = 1'b1;
        ack   = 1'b1;
        tick();
        start = 1'b0;
        ack   = 1'b0;
        check("both_state", state, 1);
        check("both_score", score, 2);
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        check("go2_state", state, 2);
        check("go2_hs", high_score, 5);
        check("go2_score", score, 2);

        // ---------------- Reset mid-game acts immediately ----------------
        ack = 1'b1;
        tick();
        ack = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        on_coin0();
        tick();
        check("pre_rst_score", score, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_state", state, 0);
        check("mid_rst_taken", taken, 0);
        check("mid_rst_pulse", pulse, 0);
        check("mid_rst_score", score, 0);
        check("mid_rst_hs", high_score, 0);

        // ---------------- Saturation on the 3-bit score build ----------------
        tick();
        reset_n = 1'b1;
        park();
        start = 1'b1;
        tick();
        start = 1'b0;
        on_coin0();
        for (int n = 0; n < 9; n++) begin
            valid = 4'b1110;
            tick();
            valid = 4'hF;
            tick();
        end
        check("sat_state3", state3, 1);
        check("sat_pulse3", pulse3, 1);
        check("sat_score3", score3, 7);
        check("sat_score8", score, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coin_tracker.md
# coin_tracker

Parametrised coin-collection tracker for Flappy-VGA. Each cycle it tests the bird's bounding box against `N_COINS` coin boxes from the coin generator. It latches a per-coin "taken" flag and issues a one-cycle collection pulse. It keeps a saturating score and a high score, and follows the Start/Ack game flow. It sits between the coin generator, the bird position logic and the VGA/score display.

## Interface
Parameters:
- `N_COINS`, 4: number of coin channels.
- `COORD_W`, 10: width of every coordinate.
- `COIN_HEIGHT`, 20: coin height in pixels.
- `SCORE_W`, 8: width of the score and high-score counters.

Ports:
- `Clk` in 1: single clock. All state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `Start` in 1: begin a game (used in QI).
- `Ack` in 1: acknowledge game over (used in QDONE).
- `Game_Over` in 1: level signal from the pole-collision logic.
- `Bird_X_L`, `Bird_X_R`, `Bird_Y_T`, `Bird_Y_B` in COORD_W: bird box.
- `Coin_X_L`, `Coin_X_R`, `Coin_Y` in N_COINS*COORD_W: packed coin edges, coin i at bits [i*COORD_W +: COORD_W].
- `Coin_Valid` in N_COINS: coin i is on screen.
- `Coin_Taken` out N_COINS: coin i has been collected. The generator hides the coin while this is set.
- `Coin_Pulse` out 1: one-cycle strobe on any collection.
- `Score` out SCORE_W: coins collected this game.
- `High_Score` out SCORE_W: best score since reset.
- `State` out 2: QI=0, QPLAY=1, QDONE=2.

## Operation
- Overlap for coin i uses strict inequalities, computed at COORD_W+1 bits so `Coin_Y+COIN_HEIGHT` cannot wrap:
  - `Bird_X_R > Coin_X_L[i]`
  - `Bird_X_L < Coin_X_R[i]`
  - `Bird_Y_B > Coin_Y[i]`
  - `Bird_Y_T < Coin_Y[i]+COIN_HEIGHT`
- Edge contact (equality) is not a hit.
- `hit[i]` = overlap[i] & Coin_Valid[i] & ~Coin_Taken[i] & (State==QPLAY) & ~Game_Over.
- Per coin i, evaluated each cycle in priority order:
  1. `Coin_Valid[i]`=0 clears `Coin_Taken[i]`. This is how the generator re-arms a coin: it drops valid for at least one cycle and then raises it with new coordinates.
  2. Otherwise `hit[i]` sets `Coin_Taken[i]`.
  3. Otherwise `Coin_Taken[i]` holds.
- A continuously overlapping coin counts exactly once until it is re-armed.
- `Coin_Pulse` = OR of all `hit[i]`, registered.
- `Score` += popcount(hit). Multiple coins in one cycle all count. The sum saturates at 2^SCORE_W-1 with no wrap.
- FSM:
  - QI: Score=0, Taken=0. `Start` → QPLAY.
  - QPLAY: collection active. `Game_Over` → QDONE, and on that same edge `High_Score` ← max(High_Score, Score).
  - QDONE: all outputs frozen, no collection. `Ack` → QI.
- `Start` outside QI is ignored. `Ack` outside QDONE is ignored.
- On entering QI, Score and Coin_Taken clear on the transition edge. High_Score is cleared only by reset.

## Timing
- Reset values (asynchronous, while reset_n=0): State=QI, Coin_Taken=0, Coin_Pulse=0, Score=0, High_Score=0.
- Latency: inputs sampled at edge k give Coin_Taken, Coin_Pulse and Score updated after edge k. One cycle total; there is no input pipeline.
- `Coin_Pulse` is high for exactly one cycle per collection event. Back-to-back hits on different coins give back-to-back pulses.
- `Game_Over` and an overlap in the same cycle: Game_Over wins. No hit, and the score committed to High_Score excludes that coin.
- `Coin_Valid` falling in the same cycle as an overlap: no hit, Taken=0.
- Reset asserted mid-game returns State to QI immediately, without waiting for a clock. Release is synchronous to the next Clk edge; the first active edge sees QI.
- The FSM holds in its current state if Start and Ack are both asserted in a state where neither is legal.

## Test plan
- Single hit: QPLAY, coin0 at X 100..120, Y 200; bird X 110..125, Y 205..215 for one cycle. Expect Coin_Pulse=1 one cycle later, Score=1, Coin_Taken=0001.
- Hold overlap: same geometry held for 50 cycles. Expect exactly one pulse and Score=1. Drop Coin_Valid[0] for 1 cycle, raise it, keep overlap. Expect Taken clears, then a second pulse and Score=2.
- Edge contact: Bird_X_R=100 with Coin_X_L=100, and separately Bird_Y_T=220 with Coin_Y=200. Expect no hit.
- Simultaneous hits: coins 1 and 3 overlapped in the same cycle. Expect one pulse, Score +2, Taken=1010.
- Saturation: SCORE_W=3, collect 9 coins. Expect Score sticks at 7.
- Game flow: Score=5, Game_Over asserted with a coin overlapping. Expect QDONE, High_Score=5, Score=5. Ack → QI with Score=0. Start, collect 2, Game_Over: High_Score stays 5. Assert reset_n=0 mid-QPLAY: all outputs 0 immediately.
